// File: rtl/l2_req_responder_if.sv
// l2_req_responder_if
// Purpose: bundles the Spandex L2 request channel (l2_req_out_*) and the
// matching response channel (l2_rsp_in_*) between one L2 and a responder.
// Modports:
//   master - the L2 side: drives requests, consumes responses.
//   slave  - the responder side: accepts requests, drives responses.
// Signals:
//   l2_req_out_valid/ready     request handshake
//   l2_req_out_coh_msg/addr    request type and line address
//   l2_req_out_word_mask/line  word mask and write data
//   l2_rsp_in_valid/ready      response handshake
//   l2_rsp_in_coh_msg/addr     response type and echoed line address
//   l2_rsp_in_word_mask/line   echoed mask and read data
//   l2_rsp_in_invack_cnt       invalidation-ack count
interface l2_req_responder_if #(
  parameter int LINE_ADDR_BITS = 26,
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_BITS      = 64,
  parameter int MSG_BITS       = 5
);
  localparam int LINE_BITS = WORDS_PER_LINE * WORD_BITS;

  logic                      l2_req_out_valid;
  logic                      l2_req_out_ready;
  logic [MSG_BITS-1:0]       l2_req_out_coh_msg;
  logic [LINE_ADDR_BITS-1:0] l2_req_out_addr;
  logic [WORDS_PER_LINE-1:0] l2_req_out_word_mask;
  logic [LINE_BITS-1:0]      l2_req_out_line;

  logic                      l2_rsp_in_valid;
  logic                      l2_rsp_in_ready;
  logic [MSG_BITS-1:0]       l2_rsp_in_coh_msg;
  logic [LINE_ADDR_BITS-1:0] l2_rsp_in_addr;
  logic [WORDS_PER_LINE-1:0] l2_rsp_in_word_mask;
  logic [LINE_BITS-1:0]      l2_rsp_in_line;
  logic [3:0]                l2_rsp_in_invack_cnt;

  modport master (
    output l2_req_out_valid, l2_req_out_coh_msg, l2_req_out_addr,
           l2_req_out_word_mask, l2_req_out_line, l2_rsp_in_ready,
    input  l2_req_out_ready, l2_rsp_in_valid, l2_rsp_in_coh_msg,
           l2_rsp_in_addr, l2_rsp_in_word_mask, l2_rsp_in_line,
           l2_rsp_in_invack_cnt
  );

  modport slave (
    input  l2_req_out_valid, l2_req_out_coh_msg, l2_req_out_addr,
           l2_req_out_word_mask, l2_req_out_line, l2_rsp_in_ready,
    output l2_req_out_ready, l2_rsp_in_valid, l2_rsp_in_coh_msg,
           l2_rsp_in_addr, l2_rsp_in_word_mask, l2_rsp_in_line,
           l2_rsp_in_invack_cnt
  );
endinterface

// File: rtl/l2_req_responder.sv
// l2_req_responder
// Purpose: memory-side stand-in for the LLC on the Spandex L2 request
// channel. Accepts one request at a time, serves reads from / commits writes
// to a private line-granular store, and returns the matching response.
// Never issues forwards.
// Optional feature: define L2_RESP_DELAY_EN to add a DELAY state and an
// 8-bit down-counter that postpones every response by RSP_DELAY cycles.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   bus      l2_req_responder_if.slave (request + response channels)
//   bad_msg  sticky flag, set by an unsupported request type
//
// state  | meaning
// IDLE   | ready for a request; latches it on handshake
// ACCESS | one-cycle store read or masked write
// DELAY  | response hold-off countdown (L2_RESP_DELAY_EN only)
// RESP   | response valid, held until consumed
module l2_req_responder #(
  parameter int LINE_ADDR_BITS = 26,
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_BITS      = 64,
  parameter int MSG_BITS       = 5,
  parameter int MEM_LINES      = 256,
  parameter int RSP_DELAY      = 4
) (
  input  logic                clk,
  input  logic                rst,
  l2_req_responder_if.slave   bus,
  output logic                bad_msg
);
  localparam int LINE_BITS = WORDS_PER_LINE * WORD_BITS;
  localparam int IDX_BITS  = $clog2(MEM_LINES);

  // Coherence message encodings, mirroring spandex_consts.svh.
  localparam logic [MSG_BITS-1:0] REQ_S      = MSG_BITS'(0);
  localparam logic [MSG_BITS-1:0] REQ_ODATA  = MSG_BITS'(1);
  localparam logic [MSG_BITS-1:0] REQ_WT     = MSG_BITS'(2);
  localparam logic [MSG_BITS-1:0] REQ_V      = MSG_BITS'(3);
  localparam logic [MSG_BITS-1:0] REQ_O      = MSG_BITS'(4);
  localparam logic [MSG_BITS-1:0] REQ_WB     = MSG_BITS'(5);
  localparam logic [MSG_BITS-1:0] RSP_S      = MSG_BITS'(0);
  localparam logic [MSG_BITS-1:0] RSP_ODATA  = MSG_BITS'(1);
  localparam logic [MSG_BITS-1:0] RSP_V      = MSG_BITS'(2);
  localparam logic [MSG_BITS-1:0] RSP_O      = MSG_BITS'(3);
  localparam logic [MSG_BITS-1:0] RSP_WT     = MSG_BITS'(4);
  localparam logic [MSG_BITS-1:0] RSP_WB_ACK = MSG_BITS'(5);

  if (RSP_DELAY < 0 || RSP_DELAY > 255) begin : g_bad_rsp_delay
    $error("RSP_DELAY must be in 0..255");
  end
  if ((1 << IDX_BITS) != MEM_LINES) begin : g_bad_mem_lines
    $error("MEM_LINES must be a power of two");
  end

  typedef enum logic [1:0] {
    IDLE, ACCESS, RESP
`ifdef L2_RESP_DELAY_EN
    , DELAY
`endif
  } state_t;

  state_t state_q, state_d;

  logic [MSG_BITS-1:0]       msg_q;
  logic [LINE_ADDR_BITS-1:0] addr_q;
  logic [WORDS_PER_LINE-1:0] mask_q;
  logic [LINE_BITS-1:0]      wline_q;
  logic [MSG_BITS-1:0]       rsp_msg_q, rsp_msg_d;
  logic [LINE_BITS-1:0]      rsp_line_q;
  logic                      bad_msg_q;
  logic                      supported, is_write, mem_we;
  logic [IDX_BITS-1:0]       idx;

  // Not reset: contents are undefined until written.
  logic [LINE_BITS-1:0] mem_q [MEM_LINES];

`ifdef L2_RESP_DELAY_EN
  logic [7:0] cnt_q;
`endif

  assign idx = addr_q[IDX_BITS-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    supported = 1'b1;
    is_write  = 1'b0;
    rsp_msg_d = RSP_V;
    bus.l2_req_out_ready = 1'b0;
    bus.l2_rsp_in_valid  = 1'b0;

    case (msg_q)
      REQ_V:     rsp_msg_d = RSP_V;
      REQ_S:     rsp_msg_d = RSP_S;
      REQ_O:     rsp_msg_d = RSP_O;
      REQ_ODATA: rsp_msg_d = RSP_ODATA;
      REQ_WT:    begin rsp_msg_d = RSP_WT;     is_write = 1'b1; end
      REQ_WB:    begin rsp_msg_d = RSP_WB_ACK; is_write = 1'b1; end
      default:   supported = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        // Gated by rst so ready reads 0 for the whole reset assertion.
        bus.l2_req_out_ready = rst;
        if (bus.l2_req_out_valid) state_d = ACCESS;
      end
      ACCESS: begin
        if (!supported) state_d = IDLE;
`ifdef L2_RESP_DELAY_EN
        else if (RSP_DELAY > 0) state_d = DELAY;
`endif
        else state_d = RESP;
      end
`ifdef L2_RESP_DELAY_EN
      DELAY: begin
        if (cnt_q == 8'd1) state_d = RESP;
      end
`endif
      RESP: begin
        bus.l2_rsp_in_valid = 1'b1;
        if (bus.l2_rsp_in_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mem_we = (state_q == ACCESS) && supported && is_write;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_q      <= '0;
      addr_q     <= '0;
      mask_q     <= '0;
      wline_q    <= '0;
      rsp_msg_q  <= '0;
      rsp_line_q <= '0;
      bad_msg_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.l2_req_out_valid) begin
        msg_q   <= bus.l2_req_out_coh_msg;
        addr_q  <= bus.l2_req_out_addr;
        mask_q  <= bus.l2_req_out_word_mask;
        wline_q <= bus.l2_req_out_line;
      end
      if (state_q == ACCESS) begin
        if (!supported) begin
          bad_msg_q <= 1'b1;
        end else begin
          rsp_msg_q  <= rsp_msg_d;
          rsp_line_q <= is_write ? '0 : mem_q[idx];
        end
      end
    end
  end

`ifdef L2_RESP_DELAY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt_q <= 8'd0;
    else if (state_q == ACCESS)  cnt_q <= 8'(RSP_DELAY);
    else if (state_q == DELAY)   cnt_q <= cnt_q - 8'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        if (mask_q[w]) mem_q[idx][w*WORD_BITS +: WORD_BITS] <= wline_q[w*WORD_BITS +: WORD_BITS];
      end
    end
  end

  // addr/mask registers only change on a new request, so they double as the
  // echoed response fields and stay stable through RESP.
  assign bus.l2_rsp_in_coh_msg    = rsp_msg_q;
  assign bus.l2_rsp_in_addr       = addr_q;
  assign bus.l2_rsp_in_word_mask  = mask_q;
  assign bus.l2_rsp_in_line       = rsp_line_q;
  assign bus.l2_rsp_in_invack_cnt = 4'd0;
  assign bad_msg                  = bad_msg_q;
endmodule

// File: tb/tb_l2_req_responder.sv
module tb_l2_req_responder;
  localparam int LAB = 26;
  localparam int WPL = 4;
  localparam int WB  = 64;
  localparam int MB  = 5;
  localparam int ML  = 256;
  localparam int RD  = 4;
  localparam int LB  = WPL * WB;
`ifdef L2_RESP_DELAY_EN
  localparam int EXP_D = RD;
`else
  localparam int EXP_D = 0;
`endif

  localparam logic [4:0] REQ_S = 5'd0, REQ_ODATA = 5'd1, REQ_WT = 5'd2,
                         REQ_V = 5'd3, REQ_O = 5'd4, REQ_WB = 5'd5;
  localparam logic [4:0] RSP_S = 5'd0, RSP_ODATA = 5'd1, RSP_V = 5'd2,
                         RSP_O = 5'd3, RSP_WT = 5'd4, RSP_WB_ACK = 5'd5;
  localparam logic [4:0] BAD_MSG = 5'd20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bad_msg;

  l2_req_responder_if #(.LINE_ADDR_BITS(LAB), .WORDS_PER_LINE(WPL),
                        .WORD_BITS(WB), .MSG_BITS(MB)) ifc ();

  l2_req_responder #(.LINE_ADDR_BITS(LAB), .WORDS_PER_LINE(WPL), .WORD_BITS(WB),
                     .MSG_BITS(MB), .MEM_LINES(ML), .RSP_DELAY(RD)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave), .bad_msg(bad_msg));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]     msg;
    logic [LAB-1:0] addr;
    logic [WPL-1:0] mask;
    logic [LB-1:0]  line;
    int             first;
  } exp_t;

  exp_t          sb[$];
  logic [LB-1:0] mdl [int];
  int checks = 0, failures = 0;
  int rdy_mode = 0;  // 0 random, 1 forced low, 2 forced high

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  // Reference model: per-word store indexed by line address modulo ML.
  function automatic logic [4:0] rsp_of(input logic [4:0] m, output bit ok, output bit wr);
    ok = 1'b1;
    wr = 1'b0;
    case (m)
      REQ_V:     return RSP_V;
      REQ_S:     return RSP_S;
      REQ_O:     return RSP_O;
      REQ_ODATA: return RSP_ODATA;
      REQ_WT:    begin wr = 1'b1; return RSP_WT; end
      REQ_WB:    begin wr = 1'b1; return RSP_WB_ACK; end
      default:   begin ok = 1'b0; return 5'd0; end
    endcase
  endfunction

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       ifc.l2_rsp_in_ready = 1'b0;
      2:       ifc.l2_rsp_in_ready = 1'b1;
      default: ifc.l2_rsp_in_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: compares every presented response with the scoreboard head.
  exp_t e;
  logic prev_v = 1'b0, prev_hs = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (ifc.l2_rsp_in_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = sb[0];
          if (!prev_v || prev_hs) chk("rsp_latency", cyc, e.first);
          chk("rsp_msg",    ifc.l2_rsp_in_coh_msg,   e.msg);
          chk("rsp_addr",   ifc.l2_rsp_in_addr,      e.addr);
          chk("rsp_mask",   ifc.l2_rsp_in_word_mask, e.mask);
          chk("rsp_line",   ifc.l2_rsp_in_line,      e.line);
          chk("rsp_invack", ifc.l2_rsp_in_invack_cnt, 0);
          chk("req_ready_in_resp", ifc.l2_req_out_ready, 0);
          if (ifc.l2_rsp_in_ready) void'(sb.pop_front());
        end
      end
      prev_v  = ifc.l2_rsp_in_valid;
      prev_hs = ifc.l2_rsp_in_valid && ifc.l2_rsp_in_ready;
    end
  end

  task automatic send(input logic [4:0] m, input logic [LAB-1:0] a, input logic [WPL-1:0] mk,
                      input logic [LB-1:0] ln, output int hs);
    int   n;
    bit   ok, wr, got;
    int   idx;
    exp_t x;
    @(posedge clk);
    #1;
    ifc.l2_req_out_valid     = 1'b1;
    ifc.l2_req_out_coh_msg   = m;
    ifc.l2_req_out_addr      = a;
    ifc.l2_req_out_word_mask = mk;
    ifc.l2_req_out_line      = ln;
    n   = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      if (ifc.l2_req_out_ready) got = 1'b1;
      else n++;
    end
    if (!got) timeout("req_accept");
    hs = cyc + 1;
    x.msg   = rsp_of(m, ok, wr);
    x.addr  = a;
    x.mask  = mk;
    x.first = hs + 1 + EXP_D;
    idx     = int'(a % ML);
    if (ok) begin
      if (wr) begin
        for (int w = 0; w < WPL; w++)
          if (mk[w]) mdl[idx][w*WB +: WB] = ln[w*WB +: WB];
        x.line = '0;
      end else begin
        x.line = mdl.exists(idx) ? mdl[idx] : 'x;
      end
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    ifc.l2_req_out_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sb.size() == 0 && ifc.l2_req_out_ready) && n < 500);
    if (n >= 500) timeout("wait_idle");
  endtask

  function automatic logic [LB-1:0] mkline(input logic [63:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [LB-1:0] rndline();
    logic [LB-1:0] l;
    for (int i = 0; i < LB / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, ifc.l2_req_out_ready, 0);
    chk({tag, "_rsp_valid"}, ifc.l2_rsp_in_valid, 0);
    chk({tag, "_rsp_msg"},   ifc.l2_rsp_in_coh_msg, 0);
    chk({tag, "_rsp_addr"},  ifc.l2_rsp_in_addr, 0);
    chk({tag, "_rsp_mask"},  ifc.l2_rsp_in_word_mask, 0);
    chk({tag, "_rsp_line"},  ifc.l2_rsp_in_line, 0);
    chk({tag, "_bad_msg"},   bad_msg, 0);
  endtask

  logic [LAB-1:0] pool [8] = '{26'h10, 26'h11, 26'h20, 26'h7F, 26'h80, 26'hFF, 26'h00, 26'h33};

  initial begin
    int hs, n;
    bit seen;
    logic [4:0] m;
    ifc.l2_req_out_valid     = 1'b0;
    ifc.l2_req_out_coh_msg   = '0;
    ifc.l2_req_out_addr      = '0;
    ifc.l2_req_out_word_mask = '0;
    ifc.l2_req_out_line      = '0;
    ifc.l2_rsp_in_ready      = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", ifc.l2_req_out_ready, 1);

    // Write then read, partial write, zero-mask write.
    send(REQ_WB, 26'h10, 4'b1111, mkline(64'd1, 64'd2, 64'd3, 64'd4), hs);
    wait_idle();
    send(REQ_V, 26'h10, 4'b0011, rndline(), hs);
    wait_idle();
    send(REQ_WT, 26'h10, 4'b0100, mkline(64'h55, 64'h66, 64'hAA, 64'h77), hs);
    wait_idle();
    send(REQ_S, 26'h10, 4'b1111, rndline(), hs);
    wait_idle();
    send(REQ_WT, 26'h10, 4'b0000, {LB{1'b1}}, hs);
    wait_idle();
    send(REQ_ODATA, 26'h10, 4'b1010, rndline(), hs);
    wait_idle();

    // Backpressure: response held for 10 cycles with ready low.
    rdy_mode = 1;
    send(REQ_O, 26'h10, 4'b1111, rndline(), hs);
    while (cyc < hs + 1 + EXP_D) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("bp_rsp_valid", ifc.l2_rsp_in_valid, 1);
      chk("bp_req_ready", ifc.l2_req_out_ready, 0);
    end
    rdy_mode = 2;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (ifc.l2_rsp_in_valid && ifc.l2_rsp_in_ready) seen = 1'b1;
      else n++;
    end
    if (!seen) timeout("bp_handshake");
    chk("bp_ready_at_handshake", ifc.l2_req_out_ready, 0);
    @(negedge clk);
    chk("bp_ready_after_handshake", ifc.l2_req_out_ready, 1);
    rdy_mode = 0;

    // Unsupported type: dropped, sticky flag, ready back two cycles later.
    send(BAD_MSG, 26'h10, 4'b1111, rndline(), hs);
    @(negedge clk);
    chk("bad_ready_access", ifc.l2_req_out_ready, 0);
    @(negedge clk);
    chk("bad_ready_return", ifc.l2_req_out_ready, 1);
    chk("bad_msg_set", bad_msg, 1);
    send(REQ_V, 26'h10, 4'b1111, rndline(), hs);
    wait_idle();
    chk("bad_msg_sticky", bad_msg, 1);

`ifdef L2_RESP_DELAY_EN
    // Reset two cycles after accept, inside DELAY.
    send(REQ_V, 26'h10, 4'b1111, rndline(), hs);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    repeat (6) begin
      @(negedge clk);
      check_reset_outputs("mid_reset");
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", ifc.l2_req_out_ready, 1);
    send(REQ_V, 26'h10, 4'b0110, rndline(), hs);
    wait_idle();
`endif

    // Randomized phase over a small address pool with aliasing.
    foreach (pool[i]) begin
      send(REQ_WB, pool[i], 4'b1111, rndline(), hs);
    end
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0:       m = REQ_V;
        1:       m = REQ_S;
        2:       m = REQ_O;
        3:       m = REQ_ODATA;
        4, 5:    m = REQ_WT;
        6, 7:    m = REQ_WB;
        8:       m = REQ_V;
        default: m = 5'($urandom_range(6, 31));
      endcase
      send(m, pool[$urandom_range(0, 7)] + LAB'(256 * $urandom_range(0, 3)),
           WPL'($urandom_range(0, 15)), rndline(), hs);
    end
    wait_idle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
